fifo_pkt_writer: RTL and testbench
==================================

# fifo_pkt_writer

Write-side packet framer for `stream_async_fifo`, living entirely in the `wclk` domain. It collects one packet from an upstream valid/ready stream into a local buffer. Once the async FIFO has room for the whole packet, it writes a length header followed by the payload as one contiguous burst. A reader on the `rclk` side never observes a partial packet. Oversized packets are dropped and counted.

## Interface
- `DSIZE`, 8, data width; must equal the FIFO `DSIZE`.
- `ASIZE`, 10, FIFO address width; FIFO depth is `2^ASIZE`.
- `LSIZE`, 4, local buffer address width; max payload is `2^LSIZE` words. Constraints: `LSIZE <= DSIZE`, `LSIZE < ASIZE`.

Ports:
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `wclk`  in  1  Clock.
- `s_data`  in  DSIZE  Upstream payload word.
- `s_valid`  in  1  Upstream word valid.
- `s_last`  in  1  Marks the final word of a packet; qualified by `s_valid`.
- `s_ready`  out  1  Accept; combinational from state.
- `w_full`  in  1  FIFO full flag.
- `wuse`  in  ASIZE  FIFO write-domain occupancy.
- `fifo_wdata`  out  DSIZE  FIFO write data; registered.
- `fifo_w_en`  out  1  FIFO write enable; registered.
- `pkt_cnt`  out  16  Packets written; wraps.
- `drop_cnt`  out  16  Packets dropped; wraps.
- `busy`  out  1  High in any state other than COLLECT.

## Operation
- States:
  - COLLECT: `s_ready`=1. Each beat with `s_valid & s_ready` stores `s_data` at buffer index `cnt`, then `cnt++`.
    - Beat with `s_last` and `cnt < 2^LSIZE`: latch `len = cnt+1`, go to WAIT.
    - Beat with no `s_last` while `cnt == 2^LSIZE`: go to DROP.
  - DROP: `s_ready`=1; beats are discarded. On the `s_last` beat: `drop_cnt++`, `cnt=0`, go to COLLECT.
  - WAIT: `s_ready`=0. Compute `free` (ASIZE+1 bits) as 0 if `w_full`, else `2^ASIZE - wuse`. When `free >= len+1`, go to HDR.
  - HDR: one cycle. Register `fifo_w_en=1`, `fifo_wdata = zero-extend(len-1)`. Go to PAY with `idx=0`.
  - PAY: one word per cycle. Register `fifo_w_en=1`, `fifo_wdata = buf[idx]`. After `idx == len-1`: `pkt_cnt++`, go to GAP.
  - GAP: exactly 2 cycles with `fifo_w_en=0`, then `cnt=0` and go to COLLECT. This lets the FIFO's registered `wuse` catch up with the burst.
- Header encoding: length-1 in bits `[LSIZE-1:0]`, all upper bits 0.
- Safety gate: `fifo_w_en` is additionally ANDed with `~w_full` when registered. A write suppressed by `w_full` is a design error; the bench asserts it never happens.
- `s_ready` is 0 in WAIT, HDR, PAY and GAP; no upstream data is accepted during a burst.
- A packet whose size is exactly `2^LSIZE` words is legal. A packet of `2^LSIZE + 1` or more words is dropped. The header is never written for a dropped packet.

## Timing
- Reset values: `fifo_w_en`=0, `fifo_wdata`=0, `pkt_cnt`=0, `drop_cnt`=0, `busy`=0, `s_ready`=1, state=COLLECT, `cnt`=0. Buffer contents are not reset.
- Reset asserted mid-burst clears `fifo_w_en` asynchronously. Any partial packet in the FIFO is the system's responsibility; the whole FIFO is reset by the same `rst_n`.
- The `s_last` beat is accepted at edge t. At t+1 the FSM is in WAIT. If space is available, HDR is registered at t+2 (`fifo_w_en` high from t+2). Payload word k is presented from t+3+k.
- Each packet takes `len+1` write cycles plus 2 GAP cycles before the next beat can be accepted.
- Back-to-back packets: minimum spacing between headers is `len + 4 + len_next` cycles.

## Structure
- Package `fifo_pkt_pkg`:
  - state enum (COLLECT, DROP, WAIT, HDR, PAY, GAP)
  - `GAP_CYCLES = 2`
  - header-encode function `hdr(len)`
- Sub-module `fifo_pkt_buf`: `2^LSIZE x DSIZE` register buffer with one synchronous write port and one asynchronous read port.
- The top level holds the FSM, counters, the space check and the output registers.

## Test plan
- Empty FIFO (`wuse`=0); packet 0xA1,0xA2,0xA3 with `s_last` on 0xA3 → FIFO writes 0x02,0xA1,0xA2,0xA3 on consecutive cycles starting 2 cycles after the `s_last` beat; `pkt_cnt`=1.
- Single-beat packet 0x55 → writes 0x00,0x55; then 16-beat packet 0x00..0x0F → header 0x0F followed by 16 words.
- 17-beat packet → no FIFO write, `drop_cnt`=1, `s_ready` held 1 throughout; the next 2-beat packet writes normally with header 0x01.
- `wuse`=1020 with a 4-word packet (needs 5, free=4) → stays in WAIT with `busy`=1 and `fifo_w_en`=0. Drop `wuse` to 1019 → HDR is issued on the next cycle.
- `w_full`=1 with `wuse`=0 (wrapped) → free=0, held in WAIT, no write.
- `rst_n` pulled low during PAY word 2 of a 5-word packet → `fifo_w_en` drops immediately. After release: `pkt_cnt`=0, state COLLECT, `s_ready`=1.

Source files
------------

// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the fifo_pkt_writer slice.
//   state_e    : framer FSM states
//   GAP_CYCLES : idle write cycles after each burst so the FIFO's registered
//                write-side occupancy catches up before the next space check
//   hdr()      : header word for a packet of len words (len-1 in the low
//                lsize bits, everything above zero)
package fifo_pkt_pkg;

  typedef enum logic [2:0] {
    COLLECT,
    DROP,
    WAIT,
    HDR,
    PAY,
    GAP
  } state_e;

  localparam int unsigned GAP_CYCLES = 2;

  function automatic logic [31:0] hdr(input logic [31:0] len, input int unsigned lsize);
    logic [31:0] mask;
    mask = (32'd1 << lsize) - 32'd1;
    return (len - 32'd1) & mask;
  endfunction

endpackage

// File: rtl/fifo_pkt_writer_buf.sv
// Local packet buffer: 2^LSIZE x DSIZE registers, one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
//   wclk  : clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational from raddr)
module fifo_pkt_buf #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned LSIZE = 4
) (
  input  logic             wclk,
  input  logic             we,
  input  logic [LSIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [LSIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  logic [DSIZE-1:0] mem [0:(1<<LSIZE)-1];

  always_ff @(posedge wclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer for stream_async_fifo (wclk domain only).
// Buffers one upstream packet, waits until the FIFO can take header plus
// payload, then writes them as one contiguous burst. Oversized packets are
// discarded and counted.
//   rst_n, wclk          : async active-low reset, clock
//   s_data/s_valid/
//   s_last/s_ready       : upstream valid/ready stream
//   w_full, wuse         : FIFO full flag and write-side occupancy
//   fifo_wdata, fifo_w_en: registered FIFO write port
//   pkt_cnt, drop_cnt    : wrapping packet counters (written / dropped)
//   busy                 : high whenever not collecting
module fifo_pkt_writer
  import fifo_pkt_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 10,
  parameter int unsigned LSIZE = 4
) (
  input  logic             rst_n,
  input  logic             wclk,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             w_full,
  input  logic [ASIZE-1:0] wuse,
  output logic [DSIZE-1:0] fifo_wdata,
  output logic             fifo_w_en,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      drop_cnt,
  output logic             busy
);

  localparam logic [LSIZE:0] DEPTH_C = {1'b1, {LSIZE{1'b0}}};

  state_e           state_q, state_d;
  logic [LSIZE:0]   cnt_q, cnt_d;
  logic [LSIZE:0]   len_q, len_d;
  logic [LSIZE-1:0] idx_q, idx_d;
  logic [1:0]       gap_q, gap_d;
  logic             w_en_q, w_en_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic             buf_we;
  logic [DSIZE-1:0] buf_rdata;
  logic [ASIZE:0]   free;
  logic [ASIZE:0]   need;
  logic [LSIZE-1:0] last_idx;

  // Beats past the buffer end are never stored; cnt_q[LSIZE] marks "full".
  assign buf_we = (state_q == COLLECT) && s_valid && !cnt_q[LSIZE];

  fifo_pkt_buf #(
    .DSIZE(DSIZE),
    .LSIZE(LSIZE)
  ) u_buf (
    .wclk (wclk),
    .we   (buf_we),
    .waddr(cnt_q[LSIZE-1:0]),
    .wdata(s_data),
    .raddr(idx_q),
    .rdata(buf_rdata)
  );

  // Space check: header + payload must fit. A full FIFO reports wuse wrapped
  // to zero, so w_full forces free to zero.
  always_comb begin
    free     = w_full ? '0 : ({1'b1, {ASIZE{1'b0}}} - {1'b0, wuse});
    need     = (ASIZE+1)'(len_q) + (ASIZE+1)'(1);
    last_idx = LSIZE'(len_q - (LSIZE+1)'(1));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    w_en_d     = 1'b0;
    wdata_d    = wdata_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;

    unique case (state_q)
      COLLECT: begin
        if (s_valid) begin
          if (cnt_q == DEPTH_C) begin
            // One beat beyond the maximum: the packet is oversized.
            cnt_d = '0;
            if (s_last) drop_cnt_d = drop_cnt_q + 16'd1;
            else        state_d    = DROP;
          end else begin
            cnt_d = cnt_q + (LSIZE+1)'(1);
            if (s_last) begin
              len_d   = cnt_q + (LSIZE+1)'(1);
              state_d = WAIT;
            end
          end
        end
      end
      DROP: begin
        if (s_valid && s_last) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          cnt_d      = '0;
          state_d    = COLLECT;
        end
      end
      WAIT: begin
        if (free >= need) state_d = HDR;
      end
      HDR: begin
        w_en_d  = 1'b1;
        wdata_d = DSIZE'(hdr(32'(len_q), LSIZE));
        idx_d   = '0;
        state_d = PAY;
      end
      PAY: begin
        w_en_d  = 1'b1;
        wdata_d = buf_rdata;
        if (idx_q == last_idx) begin
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          gap_d     = '0;
          state_d   = GAP;
        end else begin
          idx_d = idx_q + LSIZE'(1);
        end
      end
      GAP: begin
        if (gap_q == 2'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = COLLECT;
        end else begin
          gap_d = gap_q + 2'd1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      cnt_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      w_en_q     <= 1'b0;
      wdata_q    <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      // Last-ditch guard: never push into a full FIFO.
      w_en_q     <= w_en_d & ~w_full;
      wdata_q    <= wdata_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign s_ready    = (state_q == COLLECT) || (state_q == DROP);
  assign busy       = (state_q != COLLECT);
  assign fifo_w_en  = w_en_q;
  assign fifo_wdata = wdata_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Self-checking bench for fifo_pkt_writer. A packet-level model turns each
// sent packet into its expected FIFO write sequence (header then payload,
// or nothing plus a drop count for oversized packets); one negedge process
// checks every FIFO write against that queue, including header timing and
// burst contiguity. Directed scenarios add literal expectations.
module tb_fifo_pkt_writer;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned ASIZE = 10;
  localparam int unsigned LSIZE = 4;
  localparam int          MAXP  = 1 << LSIZE;

  logic             rst_n;
  logic             wclk;
  logic [DSIZE-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic             w_full;
  logic [ASIZE-1:0] wuse;
  logic [DSIZE-1:0] fifo_wdata;
  logic             fifo_w_en;
  logic [15:0]      pkt_cnt;
  logic [15:0]      drop_cnt;
  logic             busy;

  fifo_pkt_writer #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE),
    .LSIZE(LSIZE)
  ) dut (
    .rst_n     (rst_n),
    .wclk      (wclk),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .w_full    (w_full),
    .wuse      (wuse),
    .fifo_wdata(fifo_wdata),
    .fifo_w_en (fifo_w_en),
    .pkt_cnt   (pkt_cnt),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int last_wr = 0;

  always @(posedge wclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    bit         is_hdr;
    int         at;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  obs_q[$];
  logic [7:0]  pkt_data[0:31];
  logic [15:0] m_pkt  = '0;
  logic [15:0] m_drop = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Packet-level reference: legal packets produce header + payload, the
  // header due exactly hcyc; oversized ones produce nothing.
  task automatic model_pkt(input int n, input int hcyc);
    if (n <= MAXP) begin
      exp_q.push_back('{d: 8'(n - 1), is_hdr: 1'b1, at: hcyc});
      for (int k = 0; k < n; k++) exp_q.push_back('{d: pkt_data[k], is_hdr: 1'b0, at: -1});
      m_pkt = m_pkt + 16'd1;
    end else begin
      m_drop = m_drop + 16'd1;
    end
  endtask

  // Compare process: every FIFO write must match the model queue.
  always @(negedge wclk) begin
    wr_t e;
    if (rst_n && fifo_w_en) begin
      obs_q.push_back(fifo_wdata);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: wdata=%0h with nothing expected (cycle %0d)", fifo_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        check(e.is_hdr ? "hdr_data" : "pay_data", 32'(fifo_wdata), 32'(e.d));
        if (e.is_hdr) check("hdr_cycle", cyc, e.at);
        else          check("pay_contiguous", cyc, last_wr + 1);
        last_wr = cyc;
      end
    end
  end

  // Drives one packet from pkt_data[0..n-1] with random bubbles (s_last is
  // junk while s_valid is low). Returns the cycle number of the edge that
  // accepts the last beat. Once a packet has started, s_ready must stay high.
  task automatic send_pkt(input int n, input bit ready_first, output int acc);
    int guard;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_last  = 1'($urandom_range(0, 1));
        s_data  = 8'($urandom);
        @(negedge wclk);
      end
      s_valid = 1'b1;
      s_data  = pkt_data[i];
      s_last  = (i == n - 1);
      if (i > 0 || ready_first) check("s_ready_in_pkt", 32'(s_ready), 32'd1);
      guard = 0;
      while (!s_ready && guard < 300) begin
        @(negedge wclk);
        guard++;
      end
      if (guard >= 300) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout: s_ready=%b, expected 1 within 300 cycles", s_ready);
      end
      acc = cyc + 1;
      @(negedge wclk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge wclk);
    while ((exp_q.size() != 0 || busy) && g < 500) begin
      @(negedge wclk);
      g++;
    end
    if (g >= 500) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy=%b pending=%0d, expected idle", busy, exp_q.size());
    end
  endtask

  initial begin
    int acc;
    int n;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    w_full  = 1'b0;
    wuse    = '0;
    repeat (3) @(negedge wclk);

    // Reset state
    check("rst_w_en",  32'(fifo_w_en),  32'd0);
    check("rst_wdata", 32'(fifo_wdata), 32'd0);
    check("rst_pkt",   32'(pkt_cnt),    32'd0);
    check("rst_drop",  32'(drop_cnt),   32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_ready", 32'(s_ready),    32'd1);
    rst_n = 1'b1;
    @(negedge wclk);

    // 3-word packet into an empty FIFO
    pkt_data[0] = 8'hA1; pkt_data[1] = 8'hA2; pkt_data[2] = 8'hA3;
    obs_q.delete();
    send_pkt(3, 1'b1, acc);
    model_pkt(3, acc + 2);
    wait_idle();
    check("t1_nwr", obs_q.size(), 32'd4);
    check("t1_w0", 32'(obs_q[0]), 32'h02);
    check("t1_w1", 32'(obs_q[1]), 32'hA1);
    check("t1_w2", 32'(obs_q[2]), 32'hA2);
    check("t1_w3", 32'(obs_q[3]), 32'hA3);
    check("t1_pkt", 32'(pkt_cnt), 32'd1);

    // Single-beat packet, then a maximum-size packet
    pkt_data[0] = 8'h55;
    obs_q.delete();
    send_pkt(1, 1'b1, acc);
    model_pkt(1, acc + 2);
    wait_idle();
    check("t2_nwr", obs_q.size(), 32'd2);
    check("t2_hdr", 32'(obs_q[0]), 32'h00);
    check("t2_pay", 32'(obs_q[1]), 32'h55);
    for (int i = 0; i < MAXP; i++) pkt_data[i] = 8'(i);
    obs_q.delete();
    send_pkt(MAXP, 1'b1, acc);
    model_pkt(MAXP, acc + 2);
    wait_idle();
    check("t3_nwr", obs_q.size(), 32'd17);
    check("t3_hdr", 32'(obs_q[0]), 32'h0F);
    check("t3_last", 32'(obs_q[16]), 32'h0F);
    check("t3_pkt", 32'(pkt_cnt), 32'd3);

    // 17-beat packet is dropped; following 2-beat packet is normal
    for (int i = 0; i < 17; i++) pkt_data[i] = 8'($urandom);
    obs_q.delete();
    send_pkt(17, 1'b1, acc);
    model_pkt(17, 0);
    wait_idle();
    repeat (5) @(negedge wclk);
    check("t4_nwr", obs_q.size(), 32'd0);
    check("t4_drop", 32'(drop_cnt), 32'd1);
    check("t4_pkt", 32'(pkt_cnt), 32'd3);
    pkt_data[0] = 8'h3C; pkt_data[1] = 8'hC3;
    send_pkt(2, 1'b1, acc);
    model_pkt(2, acc + 2);
    wait_idle();
    check("t4_hdr", 32'(obs_q[0]), 32'h01);

    // Insufficient space: wuse=1020 leaves 4 free, a 4-word packet needs 5
    wuse = 10'd1020;
    for (int i = 0; i < 4; i++) pkt_data[i] = 8'($urandom);
    send_pkt(4, 1'b1, acc);
    repeat (10) begin
      @(negedge wclk);
      check("t5_wait_w_en", 32'(fifo_w_en), 32'd0);
      check("t5_wait_busy", 32'(busy), 32'd1);
    end
    wuse = 10'd1019;
    model_pkt(4, cyc + 2);
    wait_idle();
    wuse = '0;

    // Full FIFO (wuse wrapped to 0): no room at all
    w_full = 1'b1;
    pkt_data[0] = 8'h11; pkt_data[1] = 8'h22;
    send_pkt(2, 1'b1, acc);
    repeat (8) begin
      @(negedge wclk);
      check("t6_full_w_en", 32'(fifo_w_en), 32'd0);
      check("t6_full_busy", 32'(busy), 32'd1);
    end
    w_full = 1'b0;
    model_pkt(2, cyc + 2);
    wait_idle();
    check("t6_pkt", 32'(pkt_cnt), 32'(m_pkt));

    // Randomized packets, back to back, including oversized ones
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) pkt_data[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) wuse = 10'($urandom_range(0, 900));
      send_pkt(n, 1'b0, acc);
      model_pkt(n, acc + 2);
      if ($urandom_range(0, 4) == 0) wait_idle();
    end
    wait_idle();
    wuse = '0;
    check("rand_pkt",  32'(pkt_cnt),  32'(m_pkt));
    check("rand_drop", 32'(drop_cnt), 32'(m_drop));

    // Reset during payload word 2 of a 5-word packet
    for (int i = 0; i < 5; i++) pkt_data[i] = 8'($urandom);
    send_pkt(5, 1'b1, acc);
    model_pkt(5, acc + 2);
    while (cyc < acc + 5) @(negedge wclk);
    #2;
    check("t7_pre_w_en", 32'(fifo_w_en), 32'd1);
    check("t7_pre_data", 32'(fifo_wdata), 32'(pkt_data[2]));
    rst_n = 1'b0;
    #1;
    check("t7_async_w_en", 32'(fifo_w_en), 32'd0);
    exp_q.delete();
    m_pkt  = '0;
    m_drop = '0;
    repeat (3) @(negedge wclk);
    #2;
    rst_n = 1'b1;
    @(negedge wclk);
    check("t7_pkt",   32'(pkt_cnt),   32'd0);
    check("t7_drop",  32'(drop_cnt),  32'd0);
    check("t7_ready", 32'(s_ready),   32'd1);
    check("t7_busy",  32'(busy),      32'd0);
    check("t7_w_en",  32'(fifo_w_en), 32'd0);
    repeat (5) @(negedge wclk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
